complete_arbiter: RTL

Shares the single completion notification path (physical regfile write port plus rename-table "complete" update) among `p_num_pipes` execute pipes. Each pipe gets a one-entry completion buffer. One buffered completion is granted per cycle and broadcast on the completion bus, and buffered entries younger than an incoming squash are discarded. The block sits between the execute/writeback stages and the decode-issue unit's regfile and rename table.

---
 rtl/complete_arbiter_pkg.sv | 25 ++
 rtl/complete_arbiter_rr_arbiter.sv | 44 ++++
 rtl/complete_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/complete_arbiter_pkg.sv
// rtl/complete_arbiter_pkg.sv - shared types and sequence-age helper for complete_arbiter
package complete_arbiter_pkg;

  localparam int C_WADDR_BITS = 5;
  localparam int C_WDATA_BITS = 32;

  // Fixed-width payload of one completion buffer; seq and preg widths are module parameters.
  typedef struct packed {
    logic [C_WADDR_BITS-1:0] waddr;
    logic [C_WDATA_BITS-1:0] wdata;
    logic                    wen;
  } complete_entry_t;

  // True when a is strictly older than b under wrap-around at 'bits' width.
  function automatic logic is_older(input logic [31:0] a, input logic [31:0] b, input int bits);
    logic [31:0] mask;
    logic [31:0] diff;
    logic [31:0] half;
    mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    diff = (b - a) & mask;
    half = 32'd1 << (bits - 1);
    return (diff != 32'd0) && (diff < half);
  endfunction

endpackage

// File: rtl/complete_arbiter_rr_arbiter.sv
// rtl/complete_arbiter_rr_arbiter.sv - round-robin one-hot arbiter with internal last-grant pointer
module complete_arbiter_rr_arbiter #(
  parameter int p_width = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] req,
  input  logic               en,
  output logic [p_width-1:0] grant
);

  localparam int C_PTR_BITS = (p_width > 1) ? $clog2(p_width) : 1;

  logic [C_PTR_BITS-1:0] r_last;
  logic [C_PTR_BITS-1:0] w_grant_idx;
  logic                  w_found;
  int                    w_idx;

  // Search for the first requester starting one past the last grant.
  always_comb begin
    grant       = '0;
    w_found     = 1'b0;
    w_grant_idx = r_last;
    w_idx       = 0;
    for (int k = 0; k < p_width; k++) begin
      w_idx = (int'(r_last) + 1 + k) % p_width;
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_grant_idx  = C_PTR_BITS'(w_idx);
      end
    end
  end

  // Pointer starts at the top so requester 0 wins first; moves only on an actual grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= C_PTR_BITS'(p_width - 1);
    end else if (en && w_found) begin
      r_last <= w_grant_idx;
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// rtl/complete_arbiter.sv - per-pipe completion buffers arbitrated onto one completion bus (option: COMPLETE_ARBITER_AGE_PRIORITY_EN)
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int p_num_pipes      = 2,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [p_num_pipes-1:0]                   req_val,
  output logic [p_num_pipes-1:0]                   req_rdy,
  input  logic [p_num_pipes*p_seq_num_bits-1:0]    req_seq_num,
  input  logic [p_num_pipes*C_WADDR_BITS-1:0]      req_waddr,
  input  logic [p_num_pipes*p_phys_addr_bits-1:0]  req_preg,
  input  logic [p_num_pipes*C_WDATA_BITS-1:0]      req_wdata,
  input  logic [p_num_pipes-1:0]                   req_wen,
  input  logic                                     squash_val,
  input  logic [p_seq_num_bits-1:0]                squash_seq_num,
  output logic                                     complete_val,
  output logic [p_seq_num_bits-1:0]                complete_seq_num,
  output logic [C_WADDR_BITS-1:0]                  complete_waddr,
  output logic [p_phys_addr_bits-1:0]              complete_preg,
  output logic [C_WDATA_BITS-1:0]                  complete_wdata,
  output logic                                     complete_wen
);

  logic [p_num_pipes-1:0]      r_val;
  logic [p_seq_num_bits-1:0]   r_seq  [p_num_pipes];
  logic [p_phys_addr_bits-1:0] r_preg [p_num_pipes];
  complete_entry_t             r_ent  [p_num_pipes];

  logic [p_num_pipes-1:0]      w_elig;
  logic [p_num_pipes-1:0]      w_in_kill;
  logic [p_num_pipes-1:0]      w_grant;

  // Squash filtering of buffered and incoming entries happens before arbitration.
  always_comb begin
    w_elig    = '0;
    w_in_kill = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      w_elig[i]    = r_val[i] &
                     ~(squash_val & is_older(32'(squash_seq_num), 32'(r_seq[i]), p_seq_num_bits));
      w_in_kill[i] = squash_val &
                     is_older(32'(squash_seq_num), 32'(req_seq_num[i*p_seq_num_bits +: p_seq_num_bits]),
                              p_seq_num_bits);
    end
  end

`ifdef COMPLETE_ARBITER_AGE_PRIORITY_EN
  logic [p_num_pipes-1:0] w_beaten;

  // Oldest eligible entry wins; seq numbers are unique so exactly one survives.
  always_comb begin
    w_beaten = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      for (int j = 0; j < p_num_pipes; j++) begin
        if (j != i && w_elig[i] && w_elig[j] &&
            is_older(32'(r_seq[j]), 32'(r_seq[i]), p_seq_num_bits)) begin
          w_beaten[i] = 1'b1;
        end
      end
    end
    w_grant = w_elig & ~w_beaten;
  end
`else
  complete_arbiter_rr_arbiter #(
    .p_width (p_num_pipes)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (w_elig),
    .en    (1'b1),
    .grant (w_grant)
  );
`endif

  assign req_rdy      = ~r_val | w_grant;
  assign complete_val = |w_grant;

  // Valid bits: load on handshake (dropped if squashed on arrival), clear on grant or squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
    end else begin
      for (int i = 0; i < p_num_pipes; i++) begin
        if (req_val[i] && req_rdy[i]) begin
          r_val[i] <= ~w_in_kill[i];
        end else if (w_grant[i] || !w_elig[i]) begin
          r_val[i] <= 1'b0;
        end
      end
    end
  end

  // Payload registers capture on every accepted request; validity is tracked separately.
  always_ff @(posedge clk) begin
    for (int i = 0; i < p_num_pipes; i++) begin
      if (req_val[i] && req_rdy[i]) begin
        r_seq[i]       <= req_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
        r_preg[i]      <= req_preg[i*p_phys_addr_bits +: p_phys_addr_bits];
        r_ent[i].waddr <= req_waddr[i*C_WADDR_BITS +: C_WADDR_BITS];
        r_ent[i].wdata <= req_wdata[i*C_WDATA_BITS +: C_WDATA_BITS];
        r_ent[i].wen   <= req_wen[i];
      end
    end
  end

  // Drive the completion bus from the single granted buffer.
  always_comb begin
    complete_seq_num = '0;
    complete_waddr   = '0;
    complete_preg    = '0;
    complete_wdata   = '0;
    complete_wen     = 1'b0;
    for (int i = 0; i < p_num_pipes; i++) begin
      if (w_grant[i]) begin
        complete_seq_num = r_seq[i];
        complete_waddr   = r_ent[i].waddr;
        complete_preg    = r_preg[i];
        complete_wdata   = r_ent[i].wdata;
        complete_wen     = r_ent[i].wen;
      end
    end
  end

endmodule
